// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and helpers
//
// Contents:
//   UART_DATA_BITS  - data bits per frame
//   uart_tx_state_t - transmitter FSM states
//   clks_per_bit()  - system clocks per bit period (integer divide)
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with one-cycle boundary tick
//
// Ports:
//   clk   in  system clock
//   rstn  in  asynchronous active-high reset
//   clr   in  force the counter back to 0 (start of a new frame)
//   en    in  count while high
//   tick  out high during the last clock of each bit period
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = en && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1-2 stop bits
//
// Ports:
//   clk       in  system clock, rising edge
//   rstn      in  asynchronous active-high reset
//   tx_data   in  byte to send, latched on acceptance
//   tx_valid  in  tx_data is valid
//   tx_ready  out byte can be accepted this cycle (IDLE only)
//   tx        out registered serial line, idles high
//   busy      out frame in progress (always !tx_ready)
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115_200,
    parameter bit PARITY_EN   = 1'b0,
    parameter bit PARITY_ODD  = 1'b0,
    parameter int STOP_BITS   = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam logic [2:0] LAST_DATA_BIT = 3'(UART_DATA_BITS - 1);
    localparam logic LAST_STOP_BIT = 1'(STOP_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_tx_state_t state_q, state_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic           stop_cnt_q, stop_cnt_d;
    logic [7:0]     shift_q, shift_d;
    logic           parity_q, parity_d;
    logic           tx_q, tx_d;
    logic           tx_ready_q, tx_ready_d;
    logic           busy_q, busy_d;

    logic accept;
    logic tick;

    assign accept   = tx_valid && tx_ready_q;
    assign tx_ready = tx_ready_q;
    assign tx       = tx_q;
    assign busy     = busy_q;

    // Counter is held at zero in IDLE and restarted on acceptance so the
    // start bit gets a full period regardless of what came before.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk  (clk),
        .rstn (rstn),
        .clr  (accept),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    // Next-state logic computes the value tx must show in the following
    // cycle, so the line comes straight from a flop.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (accept) begin
                    state_d    = START;
                    shift_d    = tx_data;
                    // Parity taken from the byte as latched; the shift
                    // register is consumed as bits go out.
                    parity_d   = (^tx_data) ^ PARITY_ODD;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        if (PARITY_EN) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == LAST_STOP_BIT) begin
                        state_d    = IDLE;
                        tx_ready_d = 1'b1;
                        busy_d     = 1'b0;
                    end else begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                tx_d       = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
Serialises 8-bit bytes onto the UART TX line: start bit, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
Sits directly downstream of the message generator (send_message). It consumes send_message's `message` byte through a valid/ready handshake. send_message's `ready` input is driven from this block's tx_ready.
Sole driver of the top-level serial TX pin.

Parameters:
CLK_FREQ_HZ, 50_000_000, system clock frequency.
BAUD, 115_200, line rate. CLKS_PER_BIT = CLK_FREQ_HZ/BAUD (integer divide). Elaboration error if CLKS_PER_BIT < 2.
PARITY_EN, 0, 1 = insert a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity. Ignored when PARITY_EN = 0.
STOP_BITS, 1, number of stop bits, 1 or 2. Elaboration error otherwise.

Ports:
clk  in  1  system clock; all logic on its rising edge.
rstn  in  1  reset, asynchronous, active-high.
tx_data  in  8  byte to send; sampled only on acceptance.
tx_valid  in  1  tx_data is valid.
tx_ready  out  1  block can accept a byte this cycle.
tx  out  1  serial line; idles high.
busy  out  1  high from the cycle after acceptance through the last stop-bit cycle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, tx = 1, tx_ready = 1, busy = 0.
  - Bit counter and baud counter = 0; shift register = 0.
- Reset mid-frame aborts the frame. tx returns to 1 immediately and no partial frame resumes after reset release.
- Handshake:
  - A byte is accepted on the rising edge where tx_valid && tx_ready.
  - tx_data is latched into the shift register at that edge. Later changes to tx_data are ignored until the next acceptance.
  - tx_ready = 1 only in IDLE; it drops the cycle after acceptance.
  - tx_valid while not ready: no effect, nothing queued.
- FSM states: IDLE, START, DATA, PARITY, STOP. Transitions:
  - IDLE -> START on acceptance.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN = 1) or STOP (PARITY_EN = 0) after 8 bit periods.
  - PARITY -> STOP after 1 bit period.
  - STOP -> IDLE after STOP_BITS bit periods.
- Timing:
  - tx drives the start bit (0) in the first cycle after acceptance (latency 1 clk).
  - Every bit lasts exactly CLKS_PER_BIT clocks.
  - The baud counter runs 0..CLKS_PER_BIT-1, is cleared at acceptance and wraps at each bit boundary.
- Data bits are sent LSB first. The shift register shifts right once per data-bit boundary.
- Parity bit = XOR of the 8 latched data bits, XORed again with PARITY_ODD.
- tx is registered (glitch-free); tx = 1 in IDLE and STOP.
- Frame length = (1 + 8 + PARITY_EN + STOP_BITS) * CLKS_PER_BIT clocks.
- Back-to-back frames: IDLE is entered after the last stop cycle, so tx_ready = 1 one clock later. With tx_valid held high, the next start bit begins 2 clocks after the previous frame's final stop-bit cycle, i.e. exactly 1 extra idle-high clock between frames.
- busy == !tx_ready at all times.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic[2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}.
  - function clks_per_bit(clk_hz, baud).
  - localparam UART_DATA_BITS = 8.
- Sub-module uart_baud_tick (counter plus clear input, one-cycle tick output at each bit boundary). The future uart_rx reuses it.

Test Plan:
All scenarios use CLK_FREQ_HZ = 1_000_000 and BAUD = 100_000 (CLKS_PER_BIT = 10) unless stated otherwise.
1. Reset check: assert rstn for 3 clk -> tx = 1, tx_ready = 1, busy = 0. No toggles on tx for 50 clk after release with tx_valid = 0.
2. Single byte, PARITY_EN = 0, STOP_BITS = 1: one-cycle tx_valid with tx_data = 0x45 ('E') -> tx sequence 0,1,0,1,0,0,0,1,0,1, each held 10 clk, starting 1 clk after acceptance. tx_ready low for exactly 100 clk.
3. Parity: PARITY_EN = 1, PARITY_ODD = 0, byte 0x45 -> parity bit = 1, frame 110 clk. With PARITY_ODD = 1, same byte -> parity bit = 0.
4. STOP_BITS = 2 with tx_valid held high and bytes 0x00 then 0xFF:
   - Each frame is 110 clk with 20 clk of stop (tx = 1).
   - Exactly 1 idle clock lies between frames.
   - tx_data changes mid-frame do not alter the bits sent.
5. Reset mid-frame: assert rstn during data bit 3 of 0xA5 -> tx = 1 in the same cycle and tx_ready = 1. After release, a new byte 0x3C is sent cleanly with a correct frame.
6. Ignored valid: pulse tx_valid with 0x11 while busy -> no effect. The current frame completes unchanged and 0x11 is never transmitted.
